// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: FSM state encoding, default
// timing/address parameters and the bus width constants.
package sram_ctrl_pkg;

    localparam int          WAIT_CYCLES_DEF = 4;       // SRAM wait states per access
    localparam logic [31:0] BASE_ADDR_DEF   = 32'd1024; // CPU byte address of SRAM word 0

    localparam int SRAM_AW = 17;  // SRAM word address width
    localparam int CPU_DW  = 32;  // CPU data / address width
    localparam int SRAM_DW = 64;  // SRAM data bus width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one SRAM access.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : force count to zero (held while the controller is idle)
//   enable    : advance count by one per cycle
//   terminal  : count has reached WAIT_CYCLES-1 (last cycle of the access)
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    assign terminal = (count == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// CPU-to-asynchronous-SRAM bridge. One access at a time: the CPU holds
// wr_en/rd_en until ready=1; the controller latches the request, runs
// WAIT_CYCLES SRAM cycles, then spends one DONE cycle signalling ready.
//   clk, rst    : clock, synchronous active-high reset
//   wr_en/rd_en : CPU write / read request (level; write wins)
//   address     : CPU byte address, mapped to SRAM word (address-BASE_ADDR)/4
//   write_data  : CPU write word
//   read_data   : registered {odd word, even word} read result
//   ready       : 0 while an access is pending (CPU stalls)
//   SRAM_DQ     : bidirectional SRAM data bus
//   SRAM_ADDR   : SRAM word address
//   SRAM_WE_N   : SRAM write strobe, low for the first write cycle only
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [CPU_DW-1:0]  address,
    input  logic [CPU_DW-1:0]  write_data,
    output logic [SRAM_DW-1:0] read_data,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N
);

    state_t state, state_nx;

    logic [CPU_DW-1:0]  addr_q;
    logic [CPU_DW-1:0]  wdata_q;
    logic [SRAM_DW-1:0] rdata_q;
    logic               we_n_q;
    logic               cnt_clr, cnt_en, cnt_tc;
    logic               req;

    assign req = wr_en | rd_en;

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clr),
        .enable   (cnt_en),
        .terminal (cnt_tc)
    );

    // Counter sits at zero in IDLE so it reads 0 in the first access cycle.
    assign cnt_clr = (state == IDLE);
    assign cnt_en  = (state == READ) || (state == WRITE);

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        case (state)
            IDLE: begin
                ready = ~req;
                if (wr_en)
                    state_nx = WRITE;
                else if (rd_en)
                    state_nx = READ;
            end
            READ, WRITE: begin
                if (cnt_tc)
                    state_nx = DONE;
            end
            DONE: begin
                ready    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_n_q  <= 1'b1;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                addr_q  <= address;
                wdata_q <= write_data;
            end
            // Strobe is registered: low exactly in the cycle after IDLE
            // accepted a write, i.e. the first WRITE cycle.
            we_n_q <= ~((state == IDLE) && wr_en);
            if (state == READ && cnt_tc)
                rdata_q <= SRAM_DQ;
        end
    end

    // Offset is taken modulo 2^32 then truncated, so addresses below
    // BASE_ADDR wrap to the top of the SRAM instead of faulting.
    assign SRAM_ADDR = SRAM_AW'((addr_q - BASE_ADDR) >> 2);
    assign SRAM_WE_N = we_n_q;
    assign read_data = rdata_q;
    assign SRAM_DQ   = (state == WRITE) ? {{(SRAM_DW - CPU_DW){1'b0}}, wdata_q}
                                        : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

    localparam int          W    = 4;
    localparam logic [31:0] BASE = 32'd1024;
    localparam logic [63:0] SENT = 64'hA5A5_5A5A_C3C3_3C3C;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [63:0] read_data;
    logic        ready;
    wire  [63:0] sram_dq;
    logic [16:0] sram_addr;
    logic        sram_we_n;

    // SRAM device model plus a bench-side bus driver. dq_mode: 0 = release,
    // 1 = park a sentinel pattern (exposes stray controller drive),
    // 2 = return SRAM contents at the current address.
    logic [1:0]  dq_mode;
    logic [63:0] tb_val;
    logic [31:0] sram_mem [0:131071];
    wire  [63:0] dq_rd;

    // Transaction-level reference: word array and expected read register.
    logic [31:0] ref_mem [logic [16:0]];
    logic [63:0] exp_rdata;
    int          n_chk, n_fail;

    always #5 clk = ~clk;

    sram_controller #(
        .WAIT_CYCLES (W),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n)
    );

    assign dq_rd = {sram_mem[sram_addr + 17'd1], sram_mem[sram_addr]};
    always_comb tb_val = (dq_mode == 2'd2) ? dq_rd : SENT;
    assign sram_dq = (dq_mode != 2'd0) ? tb_val : 64'bz;

    always @(posedge clk)
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq[31:0];

    function automatic logic [16:0] word_of(input logic [31:0] a);
        return 17'((a - BASE) / 4);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Idle cycle with no request: controller must be ready and off the bus.
    task automatic idle_cyc();
        @(negedge clk);
        chk("idle_rdy", 64'(ready), 64'd1);
        chk("idle_we_n", 64'(sram_we_n), 64'd1);
        chk("idle_dq", sram_dq, SENT);
        chk("idle_rdata", read_data, exp_rdata);
        next_cyc();
    endtask

    // One full access: cycle 0 presents the request, cycles 1..W are the
    // SRAM access, cycle W+1 is the ready cycle. Inputs are scrambled after
    // cycle 0 to show the request was latched. keep=1 leaves the request
    // asserted into the following IDLE cycle.
    task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] wd, input bit keep);
        logic [16:0] wa;
        logic [63:0] rd_before;
        wa        = word_of(a);
        rd_before = exp_rdata;
        wr_en = wr; rd_en = rd; address = a; write_data = wd; dq_mode = 2'd1;
        @(negedge clk);
        chk("req_rdy", 64'(ready), 64'd0);
        for (int c = 1; c <= W; c++) begin
            next_cyc();
            address    = $urandom;
            write_data = $urandom;
            dq_mode    = wr ? 2'd0 : 2'd2;
            @(negedge clk);
            chk("busy_rdy", 64'(ready), 64'd0);
            chk("sram_addr", 64'(sram_addr), 64'(wa));
            chk("we_n", 64'(sram_we_n), (wr && c == 1) ? 64'd0 : 64'd1);
            chk("rdata_hold", read_data, rd_before);
            if (wr) chk("dq_wr", sram_dq, {32'h0, wd});
        end
        next_cyc();
        dq_mode = 2'd1;
        if (wr) ref_mem[wa] = wd;
        else    exp_rdata = {ref_mem[wa + 17'd1], ref_mem[wa]};
        @(negedge clk);
        chk("done_rdy", 64'(ready), 64'd1);
        chk("done_we_n", 64'(sram_we_n), 64'd1);
        chk("done_rdata", read_data, exp_rdata);
        chk("done_dq", sram_dq, SENT);
        if (wr) chk("mem", 64'(sram_mem[wa]), 64'(wd));
        next_cyc();
        if (!keep) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    endtask

    // Start an access and hit reset in its second access cycle.
    task automatic reset_abort(input bit wr, input logic [31:0] a, input logic [31:0] wd);
        logic [16:0] wa;
        wa = word_of(a);
        wr_en = wr; rd_en = ~wr; address = a; write_data = wd; dq_mode = 2'd1;
        next_cyc();
        dq_mode = wr ? 2'd0 : 2'd2;
        next_cyc();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; dq_mode = 2'd1;
        if (wr) ref_mem[wa] = wd;
        exp_rdata = 64'd0;
        @(negedge clk);
        chk("rst_rdy", 64'(ready), 64'd1);
        chk("rst_rdata", read_data, 64'd0);
        chk("rst_dq", sram_dq, SENT);
        chk("rst_we_n", 64'(sram_we_n), 64'd1);
        chk("rst_addr", 64'(sram_addr), 64'h1FF00);
        if (wr) chk("rst_mem", 64'(sram_mem[wa]), 64'(wd));
        next_cyc();
    endtask

    logic [31:0] ra;
    int          op;
    bit          kp, both;

    initial begin
        n_chk = 0; n_fail = 0; exp_rdata = 64'd0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        address = 32'd0; write_data = 32'd0; dq_mode = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rdy", 64'(ready), 64'd1);
        chk("reset_rdata", read_data, 64'd0);
        chk("reset_we_n", 64'(sram_we_n), 64'd1);
        chk("reset_addr", 64'(sram_addr), 64'h1FF00);
        chk("reset_dq", sram_dq, SENT);
        next_cyc();

        // Directed write, two-word read, write/read collision.
        access(1'b1, 1'b0, 32'h408, 32'hDEADBEEF, 1'b0); idle_cyc();
        access(1'b1, 1'b0, 32'h408, 32'h11111111, 1'b0); idle_cyc();
        access(1'b1, 1'b0, 32'h40C, 32'h22222222, 1'b0); idle_cyc();
        access(1'b0, 1'b1, 32'h408, 32'h0, 1'b0);
        chk("read_pair", read_data, 64'h2222222211111111);
        idle_cyc();
        access(1'b1, 1'b1, 32'h410, 32'h33333333, 1'b0); idle_cyc();

        // Back-to-back accesses, base word and wrapped address.
        access(1'b1, 1'b0, 32'h400, 32'hCAFE0000, 1'b1);
        access(1'b1, 1'b0, 32'h404, 32'hCAFE0001, 1'b0); idle_cyc();
        access(1'b0, 1'b1, 32'h400, 32'h0, 1'b1);
        access(1'b0, 1'b1, 32'h400, 32'h0, 1'b0); idle_cyc();
        access(1'b1, 1'b0, 32'h0, 32'h0BADF00D, 1'b0); idle_cyc();
        access(1'b1, 1'b0, 32'h4, 32'h600DF00D, 1'b0); idle_cyc();
        access(1'b0, 1'b1, 32'h0, 32'h0, 1'b0); idle_cyc();

        // Reset mid-read, then mid-write after its strobe.
        reset_abort(1'b0, 32'h408, 32'h0);
        idle_cyc();
        reset_abort(1'b1, 32'h40C, 32'h5555AAAA);
        idle_cyc();

        // Randomised traffic over a 16-word window.
        for (int i = 0; i < 16; i++) begin
            access(1'b1, 1'b0, BASE + 32'(4 * i), $urandom, 1'b0);
            idle_cyc();
        end
        for (int i = 0; i < 40; i++) begin
            op   = int'($urandom_range(0, 1));
            kp   = ($urandom_range(0, 3) == 0);
            both = ($urandom_range(0, 1) == 1);
            if (op == 0) begin
                ra = BASE + 32'(4 * $urandom_range(0, 15));
                access(1'b1, both, ra, $urandom, kp);
                if (kp) access(1'b1, both, BASE + 32'(4 * $urandom_range(0, 15)), $urandom, 1'b0);
            end else begin
                ra = BASE + 32'(4 * $urandom_range(0, 14));
                access(1'b0, 1'b1, ra, $urandom, kp);
                if (kp) access(1'b0, 1'b1, BASE + 32'(4 * $urandom_range(0, 14)), $urandom, 1'b0);
            end
            idle_cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 4, meaning SRAM access wait states per read/write (each >= 1).
REQ-002 Parameter BASE_ADDR, default 32'd1024, meaning CPU byte address that maps to SRAM word 0.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  CPU write request, level, held until ready=1.
REQ-006 rd_en  input  1  CPU read request, level, held until ready=1.
REQ-007 address  input  32  CPU byte address, word aligned.
REQ-008 write_data  input  32  CPU write word.
REQ-009 read_data  output  64  registered two-word read result {odd word, even word}.
REQ-010 ready  output  1  1 = no access pending or access completing; 0 = CPU must freeze.
REQ-011 SRAM_DQ  inout  64  SRAM data bus.
REQ-012 SRAM_ADDR  output  17  SRAM word address.
REQ-013 SRAM_WE_N  output  1  SRAM write enable, active-low.

Function
REQ-014 FSM states IDLE, READ, WRITE, DONE; IDLE is the reset state.
REQ-015 IDLE with wr_en=1 -> WRITE; with rd_en=1 and wr_en=0 -> READ; wr_en wins when both are set.
REQ-016 On leaving IDLE, address and write_data are latched; later input changes do not affect the access.
REQ-017 SRAM_ADDR = ((latched address - BASE_ADDR) >> 2), truncated to 17 bits, modulo wrap, no range error.
REQ-018 Wait counter clears on entry to READ/WRITE and increments each cycle; exit to DONE when counter = WAIT_CYCLES-1.
REQ-019 SRAM_WE_N = 0 only in the first WRITE cycle (exactly one clock per write); 1 in all other cycles.
REQ-020 SRAM_DQ driven with {32'b0, latched write_data} in all WRITE cycles; high-Z in all other states.
REQ-021 In the last READ cycle, read_data <= SRAM_DQ; read_data holds its value otherwise, including during writes.
REQ-022 ready = 1 in IDLE with no request and in DONE; ready = 0 in IDLE with a request, READ, and WRITE.
REQ-023 DONE lasts exactly one cycle and then returns to IDLE unconditionally.
REQ-024 A request still asserted in the IDLE cycle after DONE is treated as a new access.
REQ-025 Latency: request seen in cycle 0 -> ready=1 in cycle WAIT_CYCLES+1; read_data valid from that cycle.

Reset
REQ-026 rst=1 at the clock edge, including mid-access, gives next cycle: state IDLE, counter 0, read_data 0, latches 0, SRAM_WE_N 1, SRAM_DQ high-Z, ready 1.
REQ-027 A write aborted by reset after its WE_N cycle is not rolled back; a read aborted by reset does not update read_data.

Structure
REQ-028 Shared package sram_ctrl_pkg holds the state enum, the WAIT_CYCLES/BASE_ADDR defaults, and the 17/32/64 width constants.
REQ-029 One sub-module, sram_wait_counter (clear, enable, terminal-count output), is instantiated once; everything else stays in sram_controller.

Verification
REQ-030 Write 0xDEADBEEF to 0x00000408 -> SRAM_ADDR=2, WE_N low exactly one cycle, ready=1 in cycle 5, SRAM word 2 = 0xDEADBEEF.
REQ-031 Read 0x00000408 after words 2=0x11111111 and 3=0x22222222 -> read_data=0x2222222211111111 in cycle 5, DQ never driven by the controller.
REQ-032 wr_en and rd_en both asserted in the same cycle -> write is performed and no read capture occurs.
REQ-033 rst asserted in the second READ cycle -> IDLE next cycle, ready=1, read_data=0, DQ high-Z.
REQ-034 Back-to-back: request held through DONE -> a second full access starts in the IDLE cycle after DONE; address 0x00000400 -> SRAM_ADDR=0; address 0x00000000 -> wraps mod 2^17 to SRAM_ADDR=0x1FF00.
